// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller with per-source edge/level
// latching, per-source and global enables, fixed priority (highest index
// wins) and five I/O-mapped control registers.
module irq_ctrl #(
  parameter int IRQS  = 15,
  parameter int VW    = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQS-1:0]  src,
  output logic             irq,
  output logic [VW-1:0]    ivec,
  input  logic             iack,
  input  logic [2:0]       sel,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [2:0] SEL_PEND = 3'd0;
  localparam logic [2:0] SEL_SET  = 3'd1;
  localparam logic [2:0] SEL_EN   = 3'd2;
  localparam logic [2:0] SEL_MODE = 3'd3;
  localparam logic [2:0] SEL_CTRL = 3'd4;

  // Architectural state
  logic [IRQS-1:0]  r_pend;
  logic [IRQS-1:0]  r_en;
  logic [IRQS-1:0]  r_mode;
  logic [IRQS-1:0]  r_prev;
  logic             r_gie;
  logic             r_armed;   // low for the first cycle after reset so a held-high src does not look like a rise
  logic [WIDTH-1:0] r_rdata;

  // Combinational helpers
  logic             w_we_pend;
  logic             w_we_set;
  logic             w_we_en;
  logic             w_we_mode;
  logic             w_we_ctrl;
  logic [IRQS-1:0]  w_act;
  logic [VW-1:0]    w_ivec;
  logic [IRQS-1:0]  w_rise;
  logic [IRQS-1:0]  w_set;
  logic [IRQS-1:0]  w_clr;
  logic [IRQS-1:0]  w_ack;
  logic [IRQS-1:0]  w_pend_next;
  logic [WIDTH-1:0] w_rdata_next;

  assign w_we_pend = wr && (sel == SEL_PEND);
  assign w_we_set  = wr && (sel == SEL_SET);
  assign w_we_en   = wr && (sel == SEL_EN);
  assign w_we_mode = wr && (sel == SEL_MODE);
  assign w_we_ctrl = wr && (sel == SEL_CTRL);

  // Active sources; rst_n gating keeps irq/ivec low while reset is asserted
  assign w_act = r_pend & r_en & {IRQS{r_gie & rst_n}};

  // Priority encoder: the highest active index wins, 0 means none
  always_comb begin
    w_ivec = '0;
    for (int i = 0; i < IRQS; i++) begin
      if (w_act[i]) begin
        w_ivec = VW'(i + 1);
      end
    end
  end

  assign ivec = w_ivec;
  assign irq  = (w_ivec != '0);

  // Per-source pending next-state: edge mode latches (set beats clear), level mode copies src
  generate
    for (genvar gi = 0; gi < IRQS; gi++) begin : g_src
      assign w_rise[gi]      = src[gi] & ~r_prev[gi] & r_armed;
      assign w_ack[gi]       = iack && (w_ivec == VW'(gi + 1));
      assign w_set[gi]       = w_rise[gi] | (w_we_set & wdata[gi]);
      assign w_clr[gi]       = (w_we_pend & wdata[gi]) | w_ack[gi];
      assign w_pend_next[gi] = r_mode[gi] ? src[gi]
                                          : (w_set[gi] | (r_pend[gi] & ~w_clr[gi]));
    end
  endgenerate

  // Read mux over pre-write register state
  always_comb begin
    w_rdata_next = '0;
    case (sel)
      SEL_PEND: w_rdata_next[IRQS-1:0] = r_pend;
      SEL_EN:   w_rdata_next[IRQS-1:0] = r_en;
      SEL_MODE: w_rdata_next[IRQS-1:0] = r_mode;
      SEL_CTRL: begin
        w_rdata_next[0]      = r_gie;
        w_rdata_next[VW+7:8] = w_ivec;
      end
      default:  w_rdata_next = '0;
    endcase
  end

  assign rdata = r_rdata;

  // State update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_en    <= '0;
      r_mode  <= '0;
      r_prev  <= '0;
      r_gie   <= 1'b0;
      r_armed <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_pend  <= w_pend_next;
      r_prev  <= src;
      r_armed <= 1'b1;
      if (w_we_en) begin
        r_en <= wdata[IRQS-1:0];
      end
      if (w_we_mode) begin
        r_mode <= wdata[IRQS-1:0];
      end
      if (w_we_ctrl) begin
        r_gie <= wdata[0];
      end
      if (rd) begin
        r_rdata <= w_rdata_next;
      end
    end
  end

endmodule
